// File: rtl/xif_tracker_pkg.sv
// Shared types for the XIF offload tracker: entry states, fixed payload field
// widths that line up with the XIF x_result_t layout, and a small helper.
package xif_tracker_pkg;

  typedef enum logic [1:0] {
    ENTRY_FREE      = 2'd0,
    ENTRY_ISSUED    = 2'd1,
    ENTRY_COMMITTED = 2'd2
  } entry_state_e;

  localparam int unsigned RdWidth      = 5;
  localparam int unsigned ExcCodeWidth = 6;

  // An entry is live from allocation until its result (or kill) frees it.
  function automatic logic entry_is_live(entry_state_e state);
    return (state != ENTRY_FREE);
  endfunction

endpackage

// File: rtl/xif_offload_tracker_checker.sv
// Invariants of the tracking table: occupancy never exceeds the depth and no
// slot is ever allocated while the table is full.
module xif_offload_tracker_checker #(
  parameter int unsigned NrOutstanding = 4,
  parameter int unsigned CntWidth      = 3
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic [CntWidth-1:0] count_i,
  input logic                alloc_i,
  input logic                full_i
);

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_i <= CntWidth'(NrOutstanding));

  a_no_alloc_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(alloc_i && full_i));

endmodule

// File: rtl/xif_offload_tracker_spill.sv
// Single registered output stage (spill register with bypass disabled).
// Accepts a new payload when empty or when the held one drains this cycle,
// which gives one result per cycle of throughput.
module xif_offload_tracker_spill #(
  parameter type T = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  logic valid_r;
  T     data_r;

  assign ready_o = !valid_r || ready_i;
  assign valid_o = valid_r;
  assign data_o  = data_r;

  // Load on input handshake, drop valid once the consumer takes the payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (valid_i && ready_o) begin
      valid_r <= 1'b1;
      data_r  <= data_i;
    end else if (ready_i) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/xif_offload_tracker.sv
// Issue/commit/result scoreboard for instructions offloaded over CORE-V-XIF.
// Tracks up to NrOutstanding live IDs, orders writeback after commit, drops
// killed instructions and stalls issue while the table is full.
module xif_offload_tracker
  import xif_tracker_pkg::*;
#(
  parameter int unsigned NrOutstanding = 4,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned DataWidth     = 32,
  localparam int unsigned CntWidth     = $clog2(NrOutstanding + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    issue_valid_i,
  input  logic                    issue_ready_i,
  input  logic [IdWidth-1:0]      issue_id_i,
  input  logic                    issue_accept_i,
  input  logic                    issue_writeback_i,
  output logic                    issue_stall_o,
  input  logic                    commit_valid_i,
  input  logic                    commit_kill_i,
  input  logic [IdWidth-1:0]      commit_id_i,
  input  logic                    acc_result_valid_i,
  output logic                    acc_result_ready_o,
  input  logic [IdWidth-1:0]      acc_result_id_i,
  input  logic [DataWidth-1:0]    acc_result_data_i,
  input  logic [RdWidth-1:0]      acc_result_rd_i,
  input  logic                    acc_result_we_i,
  input  logic                    acc_result_exc_i,
  input  logic [ExcCodeWidth-1:0] acc_result_exccode_i,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic [IdWidth-1:0]      result_id_o,
  output logic [DataWidth-1:0]    result_data_o,
  output logic [RdWidth-1:0]      result_rd_o,
  output logic                    result_we_o,
  output logic                    result_exc_o,
  output logic [ExcCodeWidth-1:0] result_exccode_o,
  output logic [CntWidth-1:0]     outstanding_o,
  output logic                    err_o
);

  typedef struct packed {
    entry_state_e       state;
    logic [IdWidth-1:0] id;
    logic               wb;
  } entry_t;

  typedef struct packed {
    logic [IdWidth-1:0]      id;
    logic [DataWidth-1:0]    data;
    logic [RdWidth-1:0]      rd;
    logic                    we;
    logic                    exc;
    logic [ExcCodeWidth-1:0] exccode;
  } result_t;

  entry_t [NrOutstanding-1:0] table_r, table_s;
  logic [CntWidth-1:0]        count_r, count_s;
  logic                       err_r, err_s;

  logic [NrOutstanding-1:0] free_vec_s, issued_vec_s, committed_vec_s, wb_vec_s;
  logic [NrOutstanding-1:0] issue_match_s, commit_match_s, result_match_s, alloc_onehot_s;
  logic                     free_found_s;

  logic issue_fire_s, issue_dup_s, table_full_s, alloc_ok_s, alloc_s, new_committed_s;
  logic commit_hit_s, commit_to_new_s, commit_err_s, commit_free_s;
  logic result_hit_s, result_committed_s, result_fire_s, result_err_s, out_ready_s;
  result_t acc_payload_s, out_payload_s;

  // Per-entry status vectors and one-hot ID compares against live entries.
  always_comb begin
    free_vec_s      = '0;
    issued_vec_s    = '0;
    committed_vec_s = '0;
    wb_vec_s        = '0;
    issue_match_s   = '0;
    commit_match_s  = '0;
    result_match_s  = '0;
    for (int i = 0; i < NrOutstanding; i++) begin
      free_vec_s[i]      = !entry_is_live(table_r[i].state);
      issued_vec_s[i]    = (table_r[i].state == ENTRY_ISSUED);
      committed_vec_s[i] = (table_r[i].state == ENTRY_COMMITTED);
      wb_vec_s[i]        = table_r[i].wb;
      issue_match_s[i]   = entry_is_live(table_r[i].state) && (table_r[i].id == issue_id_i);
      commit_match_s[i]  = entry_is_live(table_r[i].state) && (table_r[i].id == commit_id_i);
      result_match_s[i]  = entry_is_live(table_r[i].state) && (table_r[i].id == acc_result_id_i);
    end
  end

  // Lowest-index free slot, as a one-hot allocation vector.
  always_comb begin
    alloc_onehot_s = '0;
    free_found_s   = 1'b0;
    for (int i = 0; i < NrOutstanding; i++) begin
      if (free_vec_s[i] && !free_found_s) begin
        alloc_onehot_s[i] = 1'b1;
        free_found_s      = 1'b1;
      end else begin
        alloc_onehot_s[i] = 1'b0;
      end
    end
  end

  // Event decode: issue, commit and result decisions plus protocol errors.
  always_comb begin
    issue_fire_s    = issue_valid_i && issue_ready_i && issue_accept_i;
    issue_dup_s     = |issue_match_s;
    table_full_s    = !free_found_s;
    alloc_ok_s      = issue_fire_s && !issue_dup_s && !table_full_s;
    commit_hit_s    = |commit_match_s;
    // A commit may target the instruction being allocated in this same cycle.
    commit_to_new_s = commit_valid_i && !commit_hit_s && alloc_ok_s && (commit_id_i == issue_id_i);
    if (commit_to_new_s) begin
      alloc_s         = !commit_kill_i && issue_writeback_i;
      new_committed_s = !commit_kill_i && issue_writeback_i;
    end else begin
      alloc_s         = alloc_ok_s;
      new_committed_s = 1'b0;
    end
    commit_err_s  = commit_valid_i && ((commit_hit_s && |(commit_match_s & committed_vec_s)) ||
                                       (!commit_hit_s && !commit_to_new_s));
    commit_free_s = commit_valid_i &&
                    |(commit_match_s & issued_vec_s & (commit_kill_i ? '1 : ~wb_vec_s));
    result_hit_s       = |result_match_s;
    result_committed_s = |(result_match_s & committed_vec_s & wb_vec_s);
    result_fire_s      = acc_result_valid_i && result_committed_s && out_ready_s;
    result_err_s       = acc_result_valid_i && !result_hit_s;
    err_s = (issue_fire_s && (issue_dup_s || table_full_s)) || commit_err_s || result_err_s;
    count_s = count_r + CntWidth'(alloc_s) - CntWidth'(commit_free_s) - CntWidth'(result_fire_s);
  end

  // Next table contents; commit, result and allocation always hit distinct slots.
  always_comb begin
    table_s = table_r;
    for (int i = 0; i < NrOutstanding; i++) begin
      if (commit_valid_i && commit_match_s[i] && issued_vec_s[i]) begin
        if (commit_kill_i || !table_r[i].wb) begin
          table_s[i].state = ENTRY_FREE;
        end else begin
          table_s[i].state = ENTRY_COMMITTED;
        end
      end else if (result_fire_s && result_match_s[i]) begin
        table_s[i].state = ENTRY_FREE;
      end else if (alloc_s && alloc_onehot_s[i]) begin
        table_s[i].state = new_committed_s ? ENTRY_COMMITTED : ENTRY_ISSUED;
        table_s[i].id    = issue_id_i;
        table_s[i].wb    = issue_writeback_i;
      end else begin
        table_s[i] = table_r[i];
      end
    end
  end

  // Table, occupancy and error-pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      table_r <= '0;
      count_r <= '0;
      err_r   <= 1'b0;
    end else begin
      table_r <= table_s;
      count_r <= count_s;
      err_r   <= err_s;
    end
  end

  assign acc_payload_s.id      = acc_result_id_i;
  assign acc_payload_s.data    = acc_result_data_i;
  assign acc_payload_s.rd      = acc_result_rd_i;
  assign acc_payload_s.we      = acc_result_we_i;
  assign acc_payload_s.exc     = acc_result_exc_i;
  assign acc_payload_s.exccode = acc_result_exccode_i;

  xif_offload_tracker_spill #(
    .T (result_t)
  ) i_out_stage (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (result_fire_s),
    .ready_o (out_ready_s),
    .data_i  (acc_payload_s),
    .valid_o (result_valid_o),
    .ready_i (result_ready_i),
    .data_o  (out_payload_s)
  );

  xif_offload_tracker_checker #(
    .NrOutstanding (NrOutstanding),
    .CntWidth      (CntWidth)
  ) i_checker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .count_i (count_r),
    .alloc_i (alloc_s),
    .full_i  (table_full_s)
  );

  assign acc_result_ready_o = result_fire_s;
  assign issue_stall_o      = (count_r == CntWidth'(NrOutstanding));
  assign outstanding_o      = count_r;
  assign err_o              = err_r;
  assign result_id_o        = out_payload_s.id;
  assign result_data_o      = out_payload_s.data;
  assign result_rd_o        = out_payload_s.rd;
  assign result_we_o        = out_payload_s.we;
  assign result_exc_o       = out_payload_s.exc;
  assign result_exccode_o   = out_payload_s.exccode;

endmodule

// File: tb/tb_xif_offload_tracker.sv
// Bench for xif_offload_tracker: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against an
// ID-keyed model of the tracking rules.
module tb_xif_offload_tracker;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int DW = 32;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic issue_valid_i = 1'b0, issue_ready_i = 1'b0, issue_accept_i = 1'b0, issue_writeback_i = 1'b0;
  logic [IW-1:0] issue_id_i = '0;
  logic issue_stall_o;
  logic commit_valid_i = 1'b0, commit_kill_i = 1'b0;
  logic [IW-1:0] commit_id_i = '0;
  logic acc_result_valid_i = 1'b0;
  logic acc_result_ready_o;
  logic [IW-1:0] acc_result_id_i = '0;
  logic [DW-1:0] acc_result_data_i = '0;
  logic [4:0] acc_result_rd_i = '0;
  logic acc_result_we_i = 1'b0, acc_result_exc_i = 1'b0;
  logic [5:0] acc_result_exccode_i = '0;
  logic result_valid_o, result_ready_i = 1'b0;
  logic [IW-1:0] result_id_o;
  logic [DW-1:0] result_data_o;
  logic [4:0] result_rd_o;
  logic result_we_o, result_exc_o;
  logic [5:0] result_exccode_o;
  logic [CW-1:0] outstanding_o;
  logic err_o;

  always #5 clk = ~clk;

  xif_offload_tracker #(.NrOutstanding(N), .IdWidth(IW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_i(issue_ready_i), .issue_id_i(issue_id_i),
    .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i), .issue_stall_o(issue_stall_o),
    .commit_valid_i(commit_valid_i), .commit_kill_i(commit_kill_i), .commit_id_i(commit_id_i),
    .acc_result_valid_i(acc_result_valid_i), .acc_result_ready_o(acc_result_ready_o),
    .acc_result_id_i(acc_result_id_i), .acc_result_data_i(acc_result_data_i),
    .acc_result_rd_i(acc_result_rd_i), .acc_result_we_i(acc_result_we_i),
    .acc_result_exc_i(acc_result_exc_i), .acc_result_exccode_i(acc_result_exccode_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .result_exc_o(result_exc_o), .result_exccode_o(result_exccode_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: per-ID liveness, commit status and writeback flag
  bit m_live[16], m_com[16], m_wb[16];
  bit n_live[16], n_com[16], n_wb[16];
  int m_cnt = 0, n_cnt = 0;
  bit m_err = 1'b0, n_err = 1'b0;
  bit o_valid = 1'b0, n_ov = 1'b0;
  logic [50:0] o_pay = '0, n_pay = '0;   // {id, data, rd, we, exc, exccode}
  int unsigned iid, cid, rid;
  bit fire, dup, full, alloc, new_com, cerr, rerr, out_rdy, acc_rdy;

  // Compare every cycle, then work out what the next cycle must look like.
  always @(negedge clk) begin
    rid     = acc_result_id_i;
    out_rdy = !o_valid || result_ready_i;
    acc_rdy = acc_result_valid_i && m_live[rid] && m_com[rid] && out_rdy;
    check("outstanding", outstanding_o, m_cnt);
    check("stall", issue_stall_o, (m_cnt == N));
    check("result_valid", result_valid_o, o_valid);
    check("result_payload", {result_id_o, result_data_o, result_rd_o, result_we_o, result_exc_o, result_exccode_o}, o_pay);
    check("err", err_o, m_err);
    check("acc_ready", acc_result_ready_o, acc_rdy);

    n_live = m_live; n_com = m_com; n_wb = m_wb; n_cnt = m_cnt;
    iid = issue_id_i; cid = commit_id_i;
    fire  = issue_valid_i && issue_ready_i && issue_accept_i;
    dup   = m_live[iid];
    full  = (m_cnt == N);
    alloc = fire && !dup && !full;
    new_com = 1'b0; cerr = 1'b0;
    if (commit_valid_i) begin
      if (m_live[cid]) begin
        if (m_com[cid]) cerr = 1'b1;
        else if (commit_kill_i || !m_wb[cid]) begin n_live[cid] = 0; n_com[cid] = 0; n_cnt--; end
        else n_com[cid] = 1'b1;
      end else if (alloc && cid == iid) begin
        if (commit_kill_i || !issue_writeback_i) alloc = 1'b0;
        else new_com = 1'b1;
      end else cerr = 1'b1;
    end
    if (alloc) begin n_live[iid] = 1; n_com[iid] = new_com; n_wb[iid] = issue_writeback_i; n_cnt++; end
    rerr = acc_result_valid_i && !m_live[rid];
    if (acc_rdy) begin n_live[rid] = 0; n_com[rid] = 0; n_cnt--; end
    n_err = (fire && (dup || full)) || cerr || rerr;
    n_ov = o_valid; n_pay = o_pay;
    if (o_valid && result_ready_i) n_ov = 1'b0;
    if (acc_rdy) begin
      n_ov  = 1'b1;
      n_pay = {acc_result_id_i, acc_result_data_i, acc_result_rd_i, acc_result_we_i, acc_result_exc_i, acc_result_exccode_i};
    end
  end

  // Model state advance; asynchronous reset empties everything at once.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) begin m_live[i] = 0; m_com[i] = 0; m_wb[i] = 0; end
      m_cnt = 0; m_err = 0; o_valid = 0; o_pay = '0;
    end else begin
      m_live = n_live; m_com = n_com; m_wb = n_wb; m_cnt = n_cnt;
      m_err = n_err; o_valid = n_ov; o_pay = n_pay;
    end
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    issue_valid_i = 0; commit_valid_i = 0; acc_result_valid_i = 0;
  endtask

  task automatic set_issue(input int id, input bit wb);
    issue_valid_i = 1; issue_ready_i = 1; issue_accept_i = 1; issue_id_i = IW'(id); issue_writeback_i = wb;
  endtask

  task automatic set_commit(input int id, input bit kill);
    commit_valid_i = 1; commit_id_i = IW'(id); commit_kill_i = kill;
  endtask

  task automatic set_res(input int id, input logic [DW-1:0] data);
    acc_result_valid_i = 1; acc_result_id_i = IW'(id); acc_result_data_i = data;
    acc_result_rd_i = 5'd1; acc_result_we_i = 1'b1; acc_result_exc_i = 1'b0; acc_result_exccode_i = 6'd0;
  endtask

  // Mostly pick a live ID in the wanted commit status, otherwise any ID.
  function automatic int pick(input bit want_com);
    int s = $urandom_range(0, 15);
    if ($urandom_range(0, 9) < 8) begin
      for (int k = 0; k < 16; k++) begin
        if (m_live[(s + k) % 16] && (m_com[(s + k) % 16] == want_com)) return (s + k) % 16;
      end
    end
    return s;
  endfunction

  bit took;

  initial begin
    #1 rst_ni = 0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1;
    result_ready_i = 1;
    @(negedge clk);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_result_valid", result_valid_o, 0);

    // Basic flow: issue, commit, result -> registered output one cycle later.
    step(); set_issue(3, 1);
    step(); clr(); set_commit(3, 0);
    @(negedge clk); check("basic_outstanding_1", outstanding_o, 1);
    step(); clr(); set_res(3, 32'hDEADBEEF);
    @(negedge clk); check("basic_acc_ready", acc_result_ready_o, 1);
    step(); clr();
    @(negedge clk);
    check("basic_result_valid", result_valid_o, 1);
    check("basic_result_id", result_id_o, 3);
    check("basic_result_data", result_data_o, 32'hDEADBEEF);
    check("basic_outstanding_0", outstanding_o, 0);

    // Kill: entry freed, later result for that ID is refused and flagged.
    step(); clr(); set_issue(5, 1);
    step(); clr(); set_commit(5, 1);
    step(); clr(); set_res(5, 32'h12345678);
    @(negedge clk); check("kill_acc_ready", acc_result_ready_o, 0);
    check("kill_outstanding", outstanding_o, 0);
    step();
    @(negedge clk); check("kill_err", err_o, 1);
    step(); clr();

    // Fill and stall, then retire one.
    for (int i = 0; i < 4; i++) begin step(); clr(); set_issue(i, 1); end
    step(); clr();
    @(negedge clk); check("fill_stall", issue_stall_o, 1); check("fill_outstanding", outstanding_o, 4);
    step(); set_commit(1, 1);
    @(negedge clk); check("fill_stall_same_cycle", issue_stall_o, 1);
    step(); clr();
    @(negedge clk); check("fill_stall_cleared", issue_stall_o, 0); check("fill_outstanding_3", outstanding_o, 3);
    step(); set_commit(0, 1);
    step(); set_commit(2, 1);
    step(); set_commit(3, 1);
    step(); clr();

    // Result before commit.
    step(); set_issue(2, 1);
    step(); clr(); set_res(2, 32'hA5A50002);
    @(negedge clk); check("early_res_ready", acc_result_ready_o, 0);
    step(); set_commit(2, 0);
    @(negedge clk); check("commit_cycle_ready", acc_result_ready_o, 0);
    step(); commit_valid_i = 0;
    @(negedge clk); check("post_commit_ready", acc_result_ready_o, 1);
    step(); clr();
    @(negedge clk); check("early_res_data", result_data_o, 32'hA5A50002);

    // Core back-pressure.
    step(); result_ready_i = 0; set_issue(8, 1);
    step(); clr(); set_issue(9, 1); set_commit(8, 0);
    step(); clr(); set_commit(9, 0); set_res(8, 32'h00000008);
    @(negedge clk); check("bp_first_ready", acc_result_ready_o, 1);
    step(); commit_valid_i = 0; set_res(9, 32'h00000009);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_valid", result_valid_o, 1);
      check("bp_hold_data", result_data_o, 32'h00000008);
      check("bp_hold_ready", acc_result_ready_o, 0);
      if (k < 2) step();
    end
    step(); result_ready_i = 1;
    @(negedge clk); check("bp_drain_ready", acc_result_ready_o, 1);
    step(); clr();
    @(negedge clk); check("bp_second_data", result_data_o, 32'h00000009);

    // Duplicate issue, then async reset drops a buffered result.
    step(); set_issue(7, 1);
    step(); set_issue(7, 1);
    step(); clr();
    @(negedge clk); check("dup_err", err_o, 1); check("dup_outstanding", outstanding_o, 1);
    step(); result_ready_i = 0; set_issue(6, 1); set_commit(6, 0);
    step(); clr(); set_res(6, 32'hCAFE0006);
    @(negedge clk); check("direct_commit_ready", acc_result_ready_o, 1);
    step(); clr();
    #2 rst_ni = 0;
    #1;
    check("arst_outstanding", outstanding_o, 0);
    check("arst_stall", issue_stall_o, 0);
    check("arst_result_valid", result_valid_o, 0);
    check("arst_result_data", result_data_o, 0);
    check("arst_err", err_o, 0);
    check("arst_acc_ready", acc_result_ready_o, 0);
    step(); rst_ni = 1; result_ready_i = 1;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      took = acc_result_valid_i && acc_result_ready_o;
      step();
      if (c == 1500) begin
        clr(); #2 rst_ni = 0;
        step(); rst_ni = 1;
        continue;
      end
      issue_valid_i     = !issue_stall_o && ($urandom_range(0, 99) < 50);
      issue_ready_i     = ($urandom_range(0, 7) != 0);
      issue_accept_i    = ($urandom_range(0, 3) != 0);
      issue_writeback_i = ($urandom_range(0, 3) != 0);
      issue_id_i        = IW'($urandom_range(0, 15));
      commit_valid_i    = ($urandom_range(0, 99) < 40);
      commit_kill_i     = ($urandom_range(0, 4) == 0);
      commit_id_i       = ($urandom_range(0, 9) == 0) ? issue_id_i : IW'(pick(1'b0));
      if (!(acc_result_valid_i && !took)) begin
        acc_result_valid_i   = ($urandom_range(0, 1) == 1);
        acc_result_id_i      = IW'(pick(1'b1));
        acc_result_data_i    = $urandom;
        acc_result_rd_i      = 5'($urandom_range(0, 31));
        acc_result_we_i      = 1'($urandom_range(0, 1));
        acc_result_exc_i     = 1'($urandom_range(0, 1));
        acc_result_exccode_i = 6'($urandom_range(0, 63));
      end
      result_ready_i = ($urandom_range(0, 9) < 7);
    end
    step(); clr();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
